// File: rtl/collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : collector_pkg
// Description : Shared types for the constraint hit collector: FSM state
//               encoding and the packed result record.
// Revision    : 1.0 - initial release
// ============================================================================
package collector_pkg;

    localparam int c_CNT_W = 16;
    localparam int c_ID_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [c_CNT_W-1:0] hits;
        logic [c_CNT_W-1:0] trials;
        logic [c_ID_W-1:0]  first_id;
        logic               found;
        logic               timeout;
    } result_t;

endpackage
`default_nettype wire

// File: rtl/constraint_hit_collector.sv
`default_nettype none
// ============================================================================
// Module      : constraint_hit_collector
// Description : Accepts tagged candidates carrying per-constraint satisfied
//               bits, counts trials and hits, and reports one result record
//               when the hit target or the trial budget is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module constraint_hit_collector
    import collector_pkg::*;
#(
    parameter int N_CONS = 8,
    parameter int CNT_W  = c_CNT_W,
    parameter int ID_W   = c_ID_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  target_hits,
    input  logic [CNT_W-1:0]  max_trials,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ID_W-1:0]   in_id,
    input  logic [N_CONS-1:0] in_cons,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  res_hits,
    output logic [CNT_W-1:0]  res_trials,
    output logic [ID_W-1:0]   res_first_id,
    output logic              res_found,
    output logic              res_timeout,
    output logic              busy
);

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_max;
    result_t          r_res;

    logic             w_accept;
    logic             w_sat;
    logic [CNT_W-1:0] w_trials_next;
    logic [CNT_W-1:0] w_hits_next;
    logic             w_hit_end;
    logic             w_budget_end;

    assign in_ready  = (r_state == ST_RUN);
    assign res_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);

    assign w_accept      = in_valid & in_ready;
    assign w_sat         = &in_cons;
    assign w_trials_next = r_res.trials + c_ONE;
    assign w_hits_next   = r_res.hits + (w_sat ? c_ONE : '0);
    // Both end conditions use post-increment values; the hit condition has priority.
    assign w_hit_end     = (r_target != '0) && (w_hits_next == r_target);
    assign w_budget_end  = (w_trials_next == r_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_target <= '0;
            r_max    <= '0;
            r_res    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_target <= target_hits;
                        r_max    <= max_trials;
                        r_res    <= '0;
                        if (max_trials == '0) begin
                            r_res.timeout <= 1'b1;
                            r_state       <= ST_DONE;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_res.trials <= w_trials_next;
                        r_res.hits   <= w_hits_next;
                        if (w_sat && !r_res.found) begin
                            r_res.first_id <= in_id;
                            r_res.found    <= 1'b1;
                        end
                        if (w_hit_end) begin
                            r_res.timeout <= 1'b0;
                            r_state       <= ST_DONE;
                        end else if (w_budget_end) begin
                            r_res.timeout <= (r_target != '0);
                            r_state       <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // A start coinciding with the handshake is deliberately dropped.
                    if (res_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign res_hits     = r_res.hits;
    assign res_trials   = r_res.trials;
    assign res_first_id = r_res.first_id;
    assign res_found    = r_res.found;
    assign res_timeout  = r_res.timeout;

endmodule
`default_nettype wire

// File: tb/tb_constraint_hit_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_constraint_hit_collector
// Description : Self-checking bench for constraint_hit_collector; expected
//               result records are queued at stimulus time and checked on
//               each result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_constraint_hit_collector;

    localparam int N  = 8;
    localparam int CW = 16;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] target_hits;
    logic [CW-1:0] max_trials;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_id;
    logic [N-1:0]  in_cons;
    logic          res_valid;
    logic          res_ready;
    logic [CW-1:0] res_hits;
    logic [CW-1:0] res_trials;
    logic [IW-1:0] res_first_id;
    logic          res_found;
    logic          res_timeout;
    logic          busy;

    typedef struct {
        logic [CW-1:0] hits;
        logic [CW-1:0] trials;
        logic [IW-1:0] first_id;
        logic          found;
        logic          timeout;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    logic [IW-1:0] c_ids[32];
    logic [N-1:0]  c_cons[32];
    int            c_n;

    constraint_hit_collector #(.N_CONS(N), .CNT_W(CW), .ID_W(IW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .target_hits(target_hits), .max_trials(max_trials),
        .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_cons(in_cons),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_hits(res_hits), .res_trials(res_trials), .res_first_id(res_first_id),
        .res_found(res_found), .res_timeout(res_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Scoreboard: every result handshake pops and checks one queued record.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: unexpected result hits=%0d trials=%0d", res_hits, res_trials);
            end else begin
                mon_e = sb.pop_front();
                if (res_hits !== mon_e.hits || res_trials !== mon_e.trials ||
                    res_first_id !== mon_e.first_id || res_found !== mon_e.found ||
                    res_timeout !== mon_e.timeout) begin
                    errors++;
                    $display("FAIL result: got hits=%0d trials=%0d id=%0d found=%0b to=%0b want hits=%0d trials=%0d id=%0d found=%0b to=%0b",
                             res_hits, res_trials, res_first_id, res_found, res_timeout,
                             mon_e.hits, mon_e.trials, mon_e.first_id, mon_e.found, mon_e.timeout);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one collection over c_ids/c_cons; ends on the negedge where res_valid is seen.
    task automatic run_stream(input logic [CW-1:0] tgt, input logic [CW-1:0] mx, input logic rdy);
        exp_t e;
        int   h, t, k, accepted;
        bit   done, seen;
        e.hits = '0; e.trials = '0; e.first_id = '0; e.found = 1'b0; e.timeout = 1'b0;
        h = 0; t = 0;
        done = (mx == 0);
        if (done) e.timeout = 1'b1;
        for (int i = 0; i < c_n && !done; i++) begin
            t++;
            if (&c_cons[i]) begin
                h++;
                if (!e.found) begin
                    e.found    = 1'b1;
                    e.first_id = c_ids[i];
                end
            end
            if (tgt != 0 && h == int'(tgt)) begin
                done = 1; e.timeout = 1'b0;
            end else if (t == int'(mx)) begin
                done = 1; e.timeout = (tgt != 0);
            end
        end
        e.hits   = h[CW-1:0];
        e.trials = t[CW-1:0];
        sb.push_back(e);

        step();
        in_valid = 1'b0; start = 1'b1; target_hits = tgt; max_trials = mx; res_ready = rdy;
        step();
        start = 1'b0;
        k = 0; accepted = 0; seen = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (k < c_n) begin
                in_valid = 1'b1; in_id = c_ids[k]; in_cons = c_cons[k];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc == 0) begin
                checks++;
                if (res_trials !== '0 || res_hits !== '0 || res_found !== 1'b0 ||
                    res_first_id !== '0 || busy !== 1'b1 || in_ready !== (mx != 0)) begin
                    errors++;
                    $display("FAIL run_start: trials=%0d hits=%0d found=%0b id=%0d busy=%0b rdy=%0b want 0 0 0 0 1 %0b",
                             res_trials, res_hits, res_found, res_first_id, busy, in_ready, (mx != 0));
                end
            end
            if (res_valid) begin
                seen = 1;
                break;
            end
            if (in_valid && in_ready) begin
                accepted++;
                k++;
            end
            step();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL run_timeout: res_valid not seen within 200 cycles");
        end else if (in_ready !== 1'b0 || accepted != t) begin
            errors++;
            $display("FAIL run_accepts: in_ready=%0b accepted=%0d want in_ready=0 accepted=%0d", in_ready, accepted, t);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; target_hits = '0; max_trials = '0;
        in_valid = 1'b0; in_id = '0; in_cons = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, res_valid, busy, res_hits, res_trials, res_first_id, res_found, res_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_state: rdy=%0b val=%0b busy=%0b hits=%0d trials=%0d id=%0d found=%0b to=%0b want all 0",
                     in_ready, res_valid, busy, res_hits, res_trials, res_first_id, res_found, res_timeout);
        end
        step();
        rst = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%0b busy=%0b want 0 0", in_ready, busy);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_target_hit();
        logic [N-1:0] pat[5];
        pat = '{8'hFF, 8'h7F, 8'hFF, 8'hFF, 8'hFF};
        c_n = 5;
        for (int i = 0; i < 5; i++) begin
            c_ids[i] = IW'(i + 1); c_cons[i] = pat[i];
        end
        run_stream(16'd2, 16'd10, 1'b1);
    endtask

    task automatic test_budget_no_hits();
        c_n = 6;
        for (int i = 0; i < 6; i++) begin
            c_ids[i] = IW'(20 + i); c_cons[i] = 8'hFE;
        end
        run_stream(16'd0, 16'd4, 1'b1);
    endtask

    task automatic test_coincide();
        c_n = 5;
        for (int i = 0; i < 5; i++) begin
            c_ids[i] = IW'(40 + i); c_cons[i] = 8'hFF;
        end
        run_stream(16'd3, 16'd3, 1'b1);
    endtask

    task automatic test_zero_budget();
        c_n = 2;
        for (int i = 0; i < 2; i++) begin
            c_ids[i] = IW'(60 + i); c_cons[i] = 8'hFF;
        end
        run_stream(16'd2, 16'd0, 1'b1);
    endtask

    task automatic test_backpressure();
        exp_t e;
        c_n = 4;
        c_ids[0] = 16'h0101; c_cons[0] = 8'h0F;
        c_ids[1] = 16'h0202; c_cons[1] = 8'hFF;
        c_ids[2] = 16'h0303; c_cons[2] = 8'hFF;
        c_ids[3] = 16'h0404; c_cons[3] = 8'hFF;
        run_stream(16'd1, 16'd5, 1'b0);
        e = sb[0];
        for (int i = 0; i < 5; i++) begin
            step();
            in_valid = 1'b0;
            start = (i == 2);
            target_hits = 16'd7; max_trials = 16'd0;
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || busy !== 1'b1 || res_hits !== e.hits || res_trials !== e.trials ||
                res_first_id !== e.first_id || res_found !== e.found || res_timeout !== e.timeout) begin
                errors++;
                $display("FAIL hold_%0d: val=%0b hits=%0d trials=%0d id=%0d found=%0b to=%0b want 1 %0d %0d %0d %0b %0b",
                         i, res_valid, res_hits, res_trials, res_first_id, res_found, res_timeout,
                         e.hits, e.trials, e.first_id, e.found, e.timeout);
            end
        end
        step();
        start = 1'b1; res_ready = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL handshake_start: busy=%0b val=%0b rdy=%0b want 0 0 0", busy, res_valid, in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            c_ids[i] = IW'(80 + i); c_cons[i] = (i == 1) ? 8'hFF : 8'h00;
        end
        run_stream(16'd0, 16'd3, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        step();
        in_valid = 1'b0; start = 1'b1; target_hits = 16'd0; max_trials = 16'd10; res_ready = 1'b1;
        step();
        start = 1'b0; in_valid = 1'b1; in_id = 16'd99; in_cons = 8'hFF;
        step();
        step();
        checks++;
        if (res_trials !== 16'd2 || res_hits !== 16'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_run: trials=%0d hits=%0d busy=%0b want 2 2 1", res_trials, res_hits, busy);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, res_valid, busy, res_hits, res_trials, res_first_id, res_found, res_timeout} !== '0) begin
            errors++;
            $display("FAIL async_reset: rdy=%0b val=%0b busy=%0b hits=%0d trials=%0d id=%0d found=%0b to=%0b want all 0",
                     in_ready, res_valid, busy, res_hits, res_trials, res_first_id, res_found, res_timeout);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_%0d: in_ready=%0b busy=%0b want 0 0", i, in_ready, busy);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [CW-1:0] tgt, mx;
        for (int r = 0; r < 4; r++) begin
            tgt = CW'($urandom_range(0, 3));
            mx  = CW'($urandom_range(1, 8));
            c_n = int'(mx) + 2;
            for (int i = 0; i < c_n; i++) begin
                c_ids[i]  = IW'($urandom_range(1, 65535));
                c_cons[i] = ($urandom_range(0, 1) == 1) ? 8'hFF : N'($urandom_range(0, 255));
            end
            run_stream(tgt, mx, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_target_hit();
        test_budget_no_hits();
        test_coincide();
        test_zero_budget();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        step();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d records never delivered", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/constraint_hit_collector.md
Name: constraint_hit_collector

Overview:
- Downstream consumer of the per-constraint evaluation modules. Each module produces one satisfied bit, for example an inequality check over two operand vectors.
- Accepts one candidate assignment per handshake, tagged with an ID and carrying the N_CONS constraint bits. A candidate is satisfying when all N_CONS bits are 1.
- Counts trials and hits, and records the ID of the first satisfying candidate.
- Ends a run on reaching the target hit count or the trial budget, then presents one result record through a valid/ready handshake.

Parameters:
N_CONS, 8, number of constraint bits per candidate (at least 1)
CNT_W, 16, width of the trial counter, the hit counter and the limit inputs
ID_W, 16, width of the candidate ID

Ports:
clk  in  1  the single clock
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle run request; honoured only in IDLE
target_hits  in  CNT_W  hits needed to end the run; 0 means run until the trial budget is spent
max_trials  in  CNT_W  trial budget; 0 means the run ends immediately with a timeout
in_valid  in  1  candidate present on the input
in_ready  out  1  collector accepts a candidate this cycle
in_id  in  ID_W  candidate identifier
in_cons  in  N_CONS  constraint-satisfied bits for the candidate
res_valid  out  1  result record valid
res_ready  in  1  downstream accepts the result record
res_hits  out  CNT_W  satisfying candidates seen in the run
res_trials  out  CNT_W  candidates accepted in the run
res_first_id  out  ID_W  ID of the first satisfying candidate; 0 if none
res_found  out  1  at least one hit occurred
res_timeout  out  1  run ended on the trial budget without reaching a nonzero target
busy  out  1  state is not IDLE

Behaviour:
- Reset is asynchronous, active-high and legal at any time, including mid-run or while a result is pending.
  - Forces state to IDLE and clears all registers.
  - All outputs reset to 0: in_ready, res_valid, busy, res_hits, res_trials, res_first_id, res_found, res_timeout.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready=0, res_valid=0.
  - start=1 latches target_hits and max_trials and clears the counters, first_id and the flags.
  - Next state is RUN. If max_trials==0, next state is DONE with timeout=1 instead.
- RUN:
  - in_ready=1 combinationally from state.
  - An accept occurs on in_valid & in_ready.
  - On accept, sat = AND-reduce of in_cons. trials increments by 1. If sat, hits increments by 1.
  - On the first sat accept of the run, first_id <= in_id and found <= 1.
  - End of run is evaluated on the accepting cycle, using the post-increment values.
    - If target!=0 and hits_next==target, go to DONE with timeout=0.
    - Otherwise, if trials_next==max_trials, go to DONE with timeout = (target!=0).
    - If both conditions hold on the same accept, the hit condition wins: timeout=0.
  - in_ready drops in DONE, so no accept happens in the cycle after the final one.
  - Counters cannot wrap because max_trials ≤ 2^CNT_W−1 bounds them.
  - start is ignored in RUN.
- DONE:
  - res_valid=1; the res_* outputs are registered and held stable until res_ready=1.
  - A res_valid & res_ready cycle returns the state to IDLE.
  - A start asserted in the same cycle as that handshake is ignored. The next run needs a start in IDLE.
- Latency:
  - Result becomes valid 1 cycle after the final accept.
  - IDLE→RUN takes 1 cycle after start.
- busy=1 in RUN and DONE.

Decomposition:
- Shared package collector_pkg:
  - state enum (IDLE, RUN, DONE).
  - packed result struct {hits, trials, first_id, found, timeout}, parameterised through localparam widths.
- No sub-module. The reduction, counters and FSM live in one module.
- The constraint modules instantiate upstream and concatenate their outputs into in_cons.

Test Plan:
1. N_CONS=8, target=2, max=10. Candidates IDs 1..5 with in_cons = 0xFF, 0x7F, 0xFF, 0xFF, 0xFF, in_valid held. Expect accepts of IDs 1–3 only, then res_valid. Required result: hits=2, trials=3, first_id=1, found=1, timeout=0. in_ready=0 from the cycle after ID 3.
2. target=0, max=4, no candidate fully satisfied (in_cons = 0xFE on every candidate). Expect hits=0, trials=4, first_id=0, found=0, timeout=0.
3. target=3, max=3, all candidates satisfied. Hit and budget end coincide on the third accept. Expect hits=3, trials=3, timeout=0.
4. max=0 with start. Expect DONE after 1 cycle with trials=0 and timeout=1, and no in_ready pulse.
5. Backpressure: in DONE, hold res_ready=0 for 5 cycles. The res_* outputs stay stable and a start pulse is ignored. Then res_ready=1 returns to IDLE; a second start begins a run with cleared counters.
6. Assert rst mid-RUN after 2 accepts. All outputs go to 0 immediately (asynchronously). After release, the state is IDLE and in_ready=0 until the next start.
